// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_arbiter
// Purpose  : Shares one single-port synchronous frame-buffer RAM between a
//            pixel fetch engine and a host port. The RAM has a read latency of
//            one cycle.
//            - The pixel requester has fixed priority.
//            - A starvation counter forces one host slot after STARVE_LIMIT
//              consecutive pixel wins while a host access is waiting.
//            - All RAM command outputs are registered.
// Ports    : clk, arst_n            - clock, asynchronous active-low reset
//            pix_req/addr/gnt       - pixel read request; grant is combinational
//            pix_rvalid/rdata       - pixel read return, two cycles after grant
//            host_req/we/addr/wdata - host request, taken while host_ready_o=1
//            host_ready/ack/rdata   - host holding-register status, ack pulse
//                                     and registered read data
//            mem_en/we/addr/wdata   - registered RAM command
//            mem_rdata_i            - RAM read data
//            pix_stall_cnt_o        - pixel stall statistics
// Config   : VGA_FB_ARB_STATS_EN - when defined, a 16-bit saturating counter
//            of pixel stall cycles drives pix_stall_cnt_o. Otherwise the
//            output is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              pix_req_i,
    input  logic [ADDR_W-1:0] pix_addr_i,
    output logic              pix_gnt_o,
    output logic              pix_rvalid_o,
    output logic [DATA_W-1:0] pix_rdata_o,
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_ready_o,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [15:0]       pix_stall_cnt_o
);

    localparam int                    C_STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_STARVE_W-1:0] C_STARVE_MAX = C_STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_WAIT    = 2'd1,
        H_ISSUED  = 2'd2,
        H_CAPTURE = 2'd3
    } host_state_t;

    host_state_t             r_state;
    host_state_t             w_state_nxt;
    logic [C_STARVE_W-1:0]   r_starve_cnt;
    logic                    r_host_we;
    logic [ADDR_W-1:0]       r_host_addr;
    logic [DATA_W-1:0]       r_host_wdata;
    logic                    r_host_ack;
    logic [DATA_W-1:0]       r_host_rdata;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic                    r_pix_inflight;
    logic                    r_pix_rvalid;
    logic                    w_host_accept;
    logic                    w_host_issue;
    logic                    w_starved;
    logic                    w_pix_gnt;

    // ------------------------------------------------------------------
    // Host FSM next state and arbitration decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_host_accept = 1'b0;
        w_host_issue  = 1'b0;
        w_starved     = (r_state == H_WAIT) && (r_starve_cnt == C_STARVE_MAX);
        case (r_state)
            H_IDLE: begin
                if (host_req_i) begin
                    w_host_accept = 1'b1;
                    w_state_nxt   = H_WAIT;
                end
            end
            H_WAIT: begin
                if (!pix_req_i || w_starved) begin
                    w_host_issue = 1'b1;
                    w_state_nxt  = H_ISSUED;
                end
            end
            H_ISSUED:  w_state_nxt = H_CAPTURE;
            H_CAPTURE: w_state_nxt = H_IDLE;
            default:   w_state_nxt = H_IDLE;
        endcase
        // A host issue only ever happens when the pixel is not granted, so the
        // two RAM command sources never collide.
        w_pix_gnt = pix_req_i && !w_starved;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= H_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Host holding register, starvation counter and completion
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_host_we    <= 1'b0;
            r_host_addr  <= '0;
            r_host_wdata <= '0;
            r_starve_cnt <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            if (w_host_accept) begin
                r_host_we    <= host_we_i;
                r_host_addr  <= host_addr_i;
                r_host_wdata <= host_wdata_i;
            end
            // Counts pixel wins while the host waits, starting from zero
            // for each new host access.
            if (w_host_accept) begin
                r_starve_cnt <= '0;
            end else if (r_state == H_WAIT && !w_host_issue
                         && r_starve_cnt != C_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + C_STARVE_W'(1);
            end
            r_host_ack <= (r_state == H_CAPTURE);
            if (r_state == H_CAPTURE && !r_host_we) begin
                r_host_rdata <= mem_rdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered RAM command and pixel return pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_pix_inflight <= 1'b0;
            r_pix_rvalid   <= 1'b0;
        end else begin
            if (w_host_issue) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= r_host_we;
                r_mem_addr  <= r_host_addr;
                r_mem_wdata <= r_host_wdata;
            end else if (w_pix_gnt) begin
                r_mem_en   <= 1'b1;
                r_mem_we   <= 1'b0;
                r_mem_addr <= pix_addr_i;
            end else begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
            end
            // Grant in N, RAM enable in N+1, data back in N+2.
            r_pix_inflight <= w_pix_gnt;
            r_pix_rvalid   <= r_pix_inflight;
        end
    end

    assign pix_gnt_o    = w_pix_gnt;
    assign pix_rvalid_o = r_pix_rvalid;
    assign pix_rdata_o  = mem_rdata_i;
    assign host_ready_o = (r_state == H_IDLE);
    assign host_ack_o   = r_host_ack;
    assign host_rdata_o = r_host_rdata;
    assign mem_en_o     = r_mem_en;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;

    // ------------------------------------------------------------------
    // Optional pixel stall statistics
    // ------------------------------------------------------------------
`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (pix_req_i && !w_pix_gnt && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign pix_stall_cnt_o = r_stall_cnt;
`else
    assign pix_stall_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates one single-port synchronous frame-buffer RAM (1-cycle read latency) between two requesters. The pixel fetch engine has fixed priority. The host port comes from the AXI-Lite slave's native read/write side. A starvation counter guarantees the host one slot at least every `STARVE_LIMIT` pixel wins. All RAM command outputs are registered.

## Interface
Parameters:
- `ADDR_W`, 16: frame-buffer word address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 8: maximum consecutive pixel wins while a host request waits. Legal range ≥ 1.

Ports:
- `clk` in 1: single clock; every register is clocked on the rising edge.
- `arst_n` in 1: asynchronous, active-low reset.
- `pix_req_i` in 1: pixel read request.
- `pix_addr_i` in `ADDR_W`: pixel read address.
- `pix_gnt_o` out 1: combinational grant; a request is taken in the cycle where `pix_req_i && pix_gnt_o`.
- `pix_rvalid_o` out 1: pixel read data valid.
- `pix_rdata_o` out `DATA_W`: `mem_rdata_i` passed through combinationally.
- `host_req_i` in 1: host access request.
- `host_we_i` in 1: 1 = write, 0 = read.
- `host_addr_i` in `ADDR_W`: host address.
- `host_wdata_i` in `DATA_W`: host write data.
- `host_ready_o` out 1: host holding register is free.
- `host_ack_o` out 1: one-cycle completion pulse.
- `host_rdata_o` out `DATA_W`: registered host read data; holds its value until the next host read ack.
- `mem_en_o` out 1: RAM enable.
- `mem_we_o` out 1: RAM write enable.
- `mem_addr_o` out `ADDR_W`: RAM address.
- `mem_wdata_o` out `DATA_W`: RAM write data.
- `mem_rdata_i` in `DATA_W`: RAM read data, valid one cycle after `mem_en_o`.
- `pix_stall_cnt_o` out 16: pixel stall statistics (see Configuration).

## Operation
- Host FSM states: HIdle, HWait, HIssued, HCapture.
  - HIdle: `host_ready_o` = 1. If `host_req_i` = 1, latch we/addr/wdata and go to HWait. A request while not ready is ignored and must be held by the requester.
  - HWait: the host wins if `!pix_req_i` or `starve_cnt == STARVE_LIMIT`; it then loads the RAM command registers and goes to HIssued. Otherwise the pixel wins and `starve_cnt` increments.
  - HIssued: always goes to HCapture.
  - HCapture: captures `mem_rdata_i` into `host_rdata_o` if the access is a read, sets the `host_ack_o` register and goes to HIdle.
- `starve_cnt` has width `$clog2(STARVE_LIMIT+1)`. It is cleared on entry to HWait and never exceeds `STARVE_LIMIT`.
- `pix_gnt_o = pix_req_i && !(state==HWait && starve_cnt==STARVE_LIMIT)`.
- RAM command register loaded per cycle, in priority order:
  - Host issue: en = 1, we = host_we.
  - Pixel grant: en = 1, we = 0, addr = `pix_addr_i`.
  - Otherwise: en = 0, we = 0; addr and wdata hold their previous values.
- Pixel requests get no arbitration while the host FSM is outside HWait; back-to-back grants are allowed every cycle.

## Timing
- Reset values:
  - `host_ready_o` = 1 (state HIdle).
  - All other outputs 0.
  - `starve_cnt` = 0.
  - `host_rdata_o` = 0.
- Pixel path:
  - Grant in cycle N.
  - `mem_en_o` = 1 in N+1.
  - `pix_rvalid_o` = 1 and `pix_rdata_o` valid in N+2.
- Host path, request accepted in cycle A:
  - HWait from A+1. The issue decision is in cycle I ≥ A+1, with I ≤ A+1+`STARVE_LIMIT`.
  - `mem_en_o` in I+1; HCapture in I+2.
  - `host_ack_o` = 1 and `host_ready_o` = 1 in I+3. A new request may be accepted in I+3.
  - Best-case latency: accept to ack in 4 cycles. Writes use the same timing as reads.
- Simultaneous `pix_req_i` and host in HWait below the starvation limit: pixel wins.
- Forced host slot: `pix_gnt_o` = 0 in that cycle even with `pix_req_i` = 1; the pixel requester holds its request.
- Reset mid-operation: a pending host access is discarded, no ack is issued, and the in-flight `pix_rvalid_o` is dropped.

## Configuration
- `VGA_FB_ARB_STATS_EN` defined: a 16-bit saturating counter drives `pix_stall_cnt_o`.
  - Increments every cycle with `pix_req_i && !pix_gnt_o`.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Not defined: `pix_stall_cnt_o` is tied to 16'h0000 and no counter logic is generated.

## Test plan
- Reset then idle: `host_ready_o` = 1; `mem_en_o`, `host_ack_o` and `pix_rvalid_o` = 0; `pix_stall_cnt_o` = 0.
- Host write, `addr` = 16'h0010, `wdata` = 32'hDEADBEEF, no pixel traffic:
  - `mem_en_o` = 1, `mem_we_o` = 1 with that addr/data at A+2.
  - `host_ack_o` pulse at A+4.
- Host read of 16'h0010 after that write:
  - `host_rdata_o` = 32'hDEADBEEF at the ack cycle.
  - `host_rdata_o` holds that value after the ack.
- Continuous `pix_req_i` with `STARVE_LIMIT` = 8 and a host read pending:
  - 8 pixel grants, then `pix_gnt_o` = 0 for exactly one cycle at A+9.
  - `host_ack_o` at A+12.
- Pixel burst at addresses 0..3, one per cycle:
  - `mem_addr_o` = 0,1,2,3 in consecutive cycles.
  - `pix_rvalid_o` high for exactly 4 cycles, two cycles after the grants.
- `arst_n` asserted while in HIssued: no `host_ack_o` afterwards and `host_ready_o` = 1. With `VGA_FB_ARB_STATS_EN` defined, the forced-slot scenario above yields `pix_stall_cnt_o` = 1.
